// File: rtl/addsub_pkg.sv
// Shared definitions for the bit-serial adder/subtractor: FSM state encoding,
// operation mode constants and a counter-width helper.
package addsub_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

    // Smallest r such that 2**r >= v; returns at least 1 so a counter always exists.
    function automatic int clog2(input int v);
        int r;
        r = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < v) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/full_addsub_cell.sv
// One-bit full adder / full subtractor. In subtract mode cin is a borrow-in
// and cout is a borrow-out; the difference bit uses the same XOR as the sum.
module full_addsub_cell
    import addsub_pkg::*;
(
    input  logic x,
    input  logic y,
    input  logic cin,
    input  logic mode,
    output logic s,
    output logic cout
);

    logic p;

    // Sum/difference bit and carry/borrow generation for the selected mode.
    always_comb begin
        p = x ^ y;
        s = p ^ cin;
        if (mode == MODE_SUB) begin
            cout = (~x & y) | (cin & ~p);
        end else begin
            cout = (x & y) | (cin & p);
        end
    end

endmodule

// File: rtl/serial_addsub.sv
// Bit-serial N-bit adder/subtractor. A start in IDLE latches the operands,
// mode and carry/borrow-in; one bit is processed per clock, LSB first, and
// after N clocks the result and final carry/borrow are published together
// with a one-cycle done pulse. Visible outputs only change at done.
//
// Handshake: start is sampled at a rising edge only while busy=0; an accepted
// start raises busy on that edge. done is a single-cycle pulse on which
// result/co_bo become valid; they then hold until the next completion.
module serial_addsub
    import addsub_pkg::*;
#(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         mode,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         ci,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] result,
    output logic         co_bo
);

    localparam int CW = clog2(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    state_t        state_q;
    state_t        state_d;
    logic [CW-1:0] cnt_q;
    logic [N-1:0]  a_q;
    logic [N-1:0]  b_q;
    logic          mode_q;
    logic          c_q;
    logic [N-1:0]  sum_q;
    logic [N-1:0]  result_q;
    logic          co_bo_q;
    logic          done_q;

    logic          cell_s;
    logic          cell_cout;
    logic          last_bit;
    logic [N-1:0]  sum_next;

    full_addsub_cell u_cell (
        .x    (a_q[0]),
        .y    (b_q[0]),
        .cin  (c_q),
        .mode (mode_q),
        .s    (cell_s),
        .cout (cell_cout)
    );

    assign last_bit = (state_q == RUN) && (cnt_q == LAST);
    assign sum_next = {cell_s, sum_q[N-1:1]};

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: IDLE waits for start, RUN leaves after the last bit.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (last_bit) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs.
    always_comb begin
        busy = (state_q == RUN);
    end

    // Operand latch, serial datapath and result publication.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            mode_q   <= MODE_ADD;
            c_q      <= 1'b0;
            sum_q    <= '0;
            result_q <= '0;
            co_bo_q  <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            // done is a pulse: only the last-bit edge can raise it.
            done_q <= last_bit;
            if (state_q == IDLE) begin
                if (start) begin
                    a_q    <= a;
                    b_q    <= b;
                    mode_q <= mode;
                    c_q    <= ci;
                    cnt_q  <= '0;
                    sum_q  <= '0;
                end
            end else begin
                a_q   <= a_q >> 1;
                b_q   <= b_q >> 1;
                c_q   <= cell_cout;
                sum_q <= sum_next;
                cnt_q <= cnt_q + CW'(1);
                if (last_bit) begin
                    result_q <= sum_next;
                    co_bo_q  <= cell_cout;
                end
            end
        end
    end

    assign done   = done_q;
    assign result = result_q;
    assign co_bo  = co_bo_q;

endmodule
